clct_win_decoder: RTL and testbench

- Consumes the best window index and priority produced by the 16-window tree encoder, and decodes it back into per-window form.
- Produces a registered one-hot window select and a blanking mask of ±blank_width windows around the winner. The second-pass pattern search uses this mask to suppress neighbours of the first CLCT.
- Holds the mask for a programmable dead time, marks itself busy, and counts candidates rejected while busy.
- Sits between the first-pass encoder and the second-best CLCT search in the TMB sequencer path.

---
 rtl/clct_win_decoder_pkg.sv | 20 ++
 rtl/clct_win_decoder_if.sv | 30 +++
 rtl/clct_blank_mask_gen.sv | 20 ++
 rtl/clct_win_decoder.sv | 112 +++++++++++
 tb/tb_clct_win_decoder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/clct_win_decoder_pkg.sv
// Shared types and sizes for the CLCT window decoder and its blank-mask helper.
package clct_win_decoder_pkg;

  localparam int NWIN     = 16;
  localparam int WINBITS  = 4;
  localparam int PRIBITS  = 4;
  localparam int DEADBITS = 4;
  localparam int DROPBITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic [NWIN-1:0] win_to_onehot(input logic [WINBITS-1:0] win);
    return NWIN'(1) << win;
  endfunction

endpackage

// File: rtl/clct_win_decoder_if.sv
// Encoder-to-decoder bus: best-window strobe, capture config, and decoded results.
interface clct_win_decoder_if;
  import clct_win_decoder_pkg::*;

  logic                win_vld;
  logic [WINBITS-1:0]  clct_win_best;
  logic [PRIBITS-1:0]  clct_pri_best;
  logic [PRIBITS-1:0]  pri_thresh;
  logic [1:0]          blank_width;
  logic [DEADBITS-1:0] dead_time;

  logic                dec_vld;
  logic [WINBITS-1:0]  dec_win;
  logic [PRIBITS-1:0]  dec_pri;
  logic [NWIN-1:0]     win_onehot;
  logic [NWIN-1:0]     blank_mask;
  logic                busy;
  logic [DROPBITS-1:0] drop_cnt;

  modport master (
    output win_vld, clct_win_best, clct_pri_best, pri_thresh, blank_width, dead_time,
    input  dec_vld, dec_win, dec_pri, win_onehot, blank_mask, busy, drop_cnt
  );

  modport slave (
    input  win_vld, clct_win_best, clct_pri_best, pri_thresh, blank_width, dead_time,
    output dec_vld, dec_win, dec_pri, win_onehot, blank_mask, busy, drop_cnt
  );

endinterface

// File: rtl/clct_blank_mask_gen.sv
// Combinational +/-width window mask around a winner, clipped at both ends (no wrap).
module clct_blank_mask_gen
  import clct_win_decoder_pkg::*;
#(
  parameter int N  = NWIN,
  parameter int WB = WINBITS
) (
  input  logic [WB-1:0] win_i,
  input  logic [1:0]    width_i,
  output logic [N-1:0]  mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < N; i++) begin
      mask_o[i] = ((i >= int'(win_i)) ? (i - int'(win_i)) : (int'(win_i) - i)) <= int'(width_i);
    end
  end

endmodule

// File: rtl/clct_win_decoder.sv
// Decodes the first-pass best window into a one-hot select and neighbour blanking
// mask, held for a programmable dead time, counting candidates rejected while busy.
module clct_win_decoder
  import clct_win_decoder_pkg::*;
(
  input logic              clock,
  input logic              reset_n,
  clct_win_decoder_if.slave bus
);

  // state   | meaning
  // IDLE    | waiting for a qualified candidate, outputs cleared
  // EMIT    | one-cycle dec_vld strobe with captured results
  // HOLD    | results held while dead counter runs down
  state_e              state_q;
  logic [DEADBITS-1:0] cnt_q;
  logic                dec_vld_q;
  logic [WINBITS-1:0]  win_q;
  logic [PRIBITS-1:0]  pri_q;
  logic [NWIN-1:0]     onehot_q;
  logic [NWIN-1:0]     mask_q;
  logic                busy_q;
  logic [DROPBITS-1:0] drop_q;

  logic [PRIBITS-1:0]  thresh_eff;
  logic                qual;
  logic [NWIN-1:0]     mask_new;

  // A zero threshold still rejects priority 0.
  assign thresh_eff = (bus.pri_thresh == '0) ? PRIBITS'(1) : bus.pri_thresh;
  assign qual       = bus.win_vld && (bus.clct_pri_best >= thresh_eff);

  clct_blank_mask_gen #(
    .N  (NWIN),
    .WB (WINBITS)
  ) u_blank_mask (
    .win_i   (bus.clct_win_best),
    .width_i (bus.blank_width),
    .mask_o  (mask_new)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dec_vld_q <= 1'b0;
      win_q     <= '0;
      pri_q     <= '0;
      onehot_q  <= '0;
      mask_q    <= '0;
      busy_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      dec_vld_q <= 1'b0;
      if (busy_q && qual && (drop_q != '1)) begin
        drop_q <= drop_q + DROPBITS'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (qual) begin
            state_q   <= ST_EMIT;
            dec_vld_q <= 1'b1;
            win_q     <= bus.clct_win_best;
            pri_q     <= bus.clct_pri_best;
            onehot_q  <= win_to_onehot(bus.clct_win_best);
            mask_q    <= mask_new;
            busy_q    <= 1'b1;
            cnt_q     <= bus.dead_time;
          end
        end
        ST_EMIT: begin
          if (cnt_q == '0) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            pri_q    <= '0;
            onehot_q <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
          end else begin
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == DEADBITS'(1)) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            pri_q    <= '0;
            onehot_q <= '0;
            mask_q   <= '0;
            busy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - DEADBITS'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dec_vld    = dec_vld_q;
  assign bus.dec_win    = win_q;
  assign bus.dec_pri    = pri_q;
  assign bus.win_onehot = onehot_q;
  assign bus.blank_mask = mask_q;
  assign bus.busy       = busy_q;
  assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_clct_win_decoder.sv
// Bench for clct_win_decoder: directed scenarios plus random traffic against a busy-window model.
module tb_clct_win_decoder;
  import clct_win_decoder_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  clct_win_decoder_if bus();

  clct_win_decoder dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_chk = 0;
  int n_bad = 0;

  // model: busy cycles remaining after the latest edge, captured results, drop count
  int          m_left = 0;
  int          m_drop = 0;
  bit          m_vld  = 0;
  int          m_win  = 0;
  int          m_pri  = 0;
  logic [15:0] m_mask = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mask(input int win, input int bw);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      int d;
      d = (i > win) ? i - win : win - i;
      if (d <= bw) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_edge(input bit rst_n, input bit vld, input int win, input int pri,
                            input int thr, input int bw, input int dead);
    bit q;
    int t;
    m_vld = 0;
    if (!rst_n) begin
      m_left = 0; m_drop = 0; m_win = 0; m_pri = 0; m_mask = '0;
      return;
    end
    t = (thr == 0) ? 1 : thr;
    q = vld && (pri >= t);
    if (m_left > 0) begin
      if (q && m_drop < 255) m_drop++;
      m_left--;
      if (m_left == 0) begin
        m_win = 0; m_pri = 0; m_mask = '0;
      end
    end else if (q) begin
      m_left = 1 + dead;
      m_vld  = 1;
      m_win  = win;
      m_pri  = pri;
      m_mask = ref_mask(win, bw);
    end
  endtask

  task automatic check_all();
    logic [15:0] oh;
    oh = (m_left > 0) ? (16'h1 << m_win) : 16'h0;
    chk("dec_vld",    32'(bus.dec_vld),    32'(m_vld));
    chk("dec_win",    32'(bus.dec_win),    32'(m_win));
    chk("dec_pri",    32'(bus.dec_pri),    32'(m_pri));
    chk("win_onehot", 32'(bus.win_onehot), 32'(oh));
    chk("blank_mask", 32'(bus.blank_mask), 32'(m_mask));
    chk("busy",       32'(bus.busy),       32'(m_left > 0));
    chk("drop_cnt",   32'(bus.drop_cnt),   32'(m_drop));
  endtask

  task automatic step(input bit vld, input int win, input int pri, input int thr,
                      input int bw, input int dead, input bit rst_n = 1'b1);
    reset_n           = rst_n;
    bus.win_vld       = vld;
    bus.clct_win_best = WINBITS'(win);
    bus.clct_pri_best = PRIBITS'(pri);
    bus.pri_thresh    = PRIBITS'(thr);
    bus.blank_width   = 2'(bw);
    bus.dead_time     = DEADBITS'(dead);
    @(posedge clock);
    model_edge(rst_n, vld, win, pri, thr, bw, dead);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.win_vld = 1'b0; bus.clct_win_best = '0; bus.clct_pri_best = '0;
    bus.pri_thresh = '0; bus.blank_width = '0; bus.dead_time = '0;
    @(negedge clock);

    // reset
    step(1'b0, 0, 0, 0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 0, 0, 1'b0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    idle(1);

    // basic: win 7, pri 9, thresh 4, bw 1, dead 2
    step(1'b1, 7, 9, 4, 1, 2);
    chk("basic_vld",  32'(bus.dec_vld),    32'd1);
    chk("basic_oh",   32'(bus.win_onehot), 32'h0080);
    chk("basic_mask", 32'(bus.blank_mask), 32'h01C0);
    step(1'b0, 3, 1, 15, 3, 15);
    chk("basic_c2_vld",  32'(bus.dec_vld), 32'd0);
    chk("basic_c2_busy", 32'(bus.busy),    32'd1);
    step(1'b0, 0, 0, 0, 0, 0);
    chk("basic_c3_busy", 32'(bus.busy),    32'd1);
    step(1'b0, 0, 0, 0, 0, 0);
    chk("basic_c4_busy", 32'(bus.busy),       32'd0);
    chk("basic_c4_mask", 32'(bus.blank_mask), 32'd0);

    // edge clipping
    step(1'b1, 0, 5, 1, 3, 0);
    chk("clip_lo", 32'(bus.blank_mask), 32'h000F);
    idle(1);
    step(1'b1, 15, 5, 1, 2, 0);
    chk("clip_hi", 32'(bus.blank_mask), 32'hE000);
    idle(1);

    // threshold and priority zero
    step(1'b1, 5, 3, 4, 1, 0);
    chk("below_thr", 32'(bus.dec_vld), 32'd0);
    step(1'b1, 5, 0, 0, 1, 0);
    chk("pri_zero",  32'(bus.dec_vld), 32'd0);
    chk("thr_drops", 32'(bus.drop_cnt), 32'd0);

    // drops while busy: 3 qualified plus 1 unqualified during HOLD
    step(1'b1, 4, 8, 2, 0, 5);
    step(1'b0, 0, 0, 0, 0, 0);
    step(1'b1, 2, 9, 2, 1, 1);
    step(1'b1, 9, 2, 2, 1, 1);
    step(1'b1, 9, 1, 2, 1, 1);
    step(1'b1, 11, 15, 0, 3, 0);
    chk("drop3_vld", 32'(bus.dec_vld),  32'd0);
    idle(2);
    chk("drop3_cnt", 32'(bus.drop_cnt), 32'd3);

    // dead=0 back-to-back after clearing the drop count
    step(1'b0, 0, 0, 0, 0, 0, 1'b0);
    step(1'b1, 3, 6, 1, 0, 0);
    step(1'b1, 8, 6, 1, 0, 0);
    chk("b2b_drop", 32'(bus.drop_cnt), 32'd1);
    step(1'b1, 10, 7, 1, 1, 0);
    chk("b2b_vld2", 32'(bus.dec_vld), 32'd1);
    chk("b2b_win2", 32'(bus.dec_win), 32'd10);
    idle(1);

    // reset mid-HOLD
    step(1'b1, 6, 12, 3, 2, 6);
    idle(2);
    step(1'b0, 0, 0, 0, 0, 0, 1'b0);
    chk("rsthold_busy", 32'(bus.busy),       32'd0);
    chk("rsthold_mask", 32'(bus.blank_mask), 32'd0);
    step(1'b1, 12, 13, 3, 1, 1);
    chk("rsthold_redo", 32'(bus.dec_vld),    32'd1);
    idle(2);

    // drop counter saturation
    for (int k = 0; k < 400; k++) step(1'b1, k % 16, 15, 1, 0, 15);
    chk("drop_sat", 32'(bus.drop_cnt), 32'd255);
    idle(17);
    step(1'b0, 0, 0, 0, 0, 0, 1'b0);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      bit rst_n;
      rst_n = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3), rst_n);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
